apb_req_master: RTL and testbench

//  - Single-outstanding APB3 master. Converts a valid/ready register-request port
//    (from the bus bridge / debug path) into SETUP/ACCESS APB transfers.
//  - Drives the APB register slaves downstream; returns read data and error as a
//    one-cycle response pulse.

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_req_master.sv | 160 ++++++++++++++++
 tb/tb_apb_req_master.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding and address alignment.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    localparam int unsigned APB_ADDR_LSB = 2;

endpackage

// File: rtl/apb_req_master.sv
// Single-outstanding APB3 master: valid/ready request port to SETUP/ACCESS transfers.
// Optional ACCESS timeout abort is enabled with APB_TIMEOUT_EN.
module apb_req_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
`ifdef APB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << APB_ADDR_LSB) - 1);

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    apb_state_e            state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            APB_IDLE: begin
                if (req_valid && req_ready_q) begin
                    paddr_d   = req_addr & ADDR_MASK;
                    pwrite_d  = req_write;
                    pwdata_d  = req_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = APB_SETUP;
`ifdef APB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            APB_SETUP: begin
                penable_d = 1'b1;
                state_d   = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
                    state_d     = APB_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                // pready in the same cycle takes priority over the abort
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = APB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = APB_IDLE;
            end
        endcase

        // Not ready while busy or while the response pulse is out
        req_ready_d = (state_d == APB_IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= APB_IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Scoreboard bench for apb_req_master: random requests, APB register-slave model,
// expected responses predicted from a word-addressed reference memory.
module tb_apb_req_master;

    logic        pclk;
    logic        presetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

`ifdef APB_TIMEOUT_EN
    localparam int TO = 8;
    apb_req_master #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
`else
    apb_req_master #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
`endif
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        w;
        logic [5:0]  paddr;
        logic [31:0] wdata;
        int          waits;
        logic        err;
    } slv_t;

    exp_t        exp_q[$];
    slv_t        slv_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc++;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // APB register slave with per-transfer wait states and error injection
    slv_t cur;
    logic cur_valid = 1'b0;
    int   wcnt = 0;
    always @(negedge pclk) begin
        if (!presetn) begin
            cur_valid = 1'b0;
            pready    = 1'b0;
            pslverr   = 1'b0;
        end else if (psel && !penable) begin
            if (slv_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_setup: got psel=1 with paddr 0x%0h, expected no transfer", paddr);
            end else begin
                cur = slv_q.pop_front();
                cur_valid = 1'b1;
                wcnt = cur.waits;
                chk("setup_paddr", 64'(paddr), 64'(cur.paddr));
                chk("setup_pwrite", 64'(pwrite), 64'(cur.w));
                if (cur.w) chk("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
            end
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end else if (psel && penable && cur_valid) begin
            chk("access_paddr", 64'(paddr), 64'(cur.paddr));
            chk("access_pwrite", 64'(pwrite), 64'(cur.w));
            if (cur.w) chk("access_pwdata", 64'(pwdata), 64'(cur.wdata));
            if (wcnt == 0) begin
                pready  = 1'b1;
                pslverr = cur.err;
                prdata  = (cur.w || cur.err) ? $urandom : slv_mem[cur.paddr[5:2]];
                if (cur.w && !cur.err) slv_mem[cur.paddr[5:2]] = cur.wdata;
                cur_valid = 1'b0;
            end else begin
                wcnt--;
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
        end else begin
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid pulse
    exp_t        e_mon;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    always @(negedge pclk) begin
        if (!presetn) begin
            last_rdata = '0;
            last_err   = 1'b0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (cycle %0d)", cyc);
            end else begin
                e_mon = exp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e_mon.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e_mon.err));
                chk("rsp_cycle", 64'(cyc), 64'(e_mon.cyc));
                chk("rsp_req_ready", 64'(req_ready), 64'd0);
                chk("rsp_psel", 64'(psel), 64'd0);
            end
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end else begin
            chk("rsp_hold", {31'd0, rsp_err, rsp_rdata}, {31'd0, last_err, last_rdata});
        end
    end

    // Issue one request; called and returns on a falling edge
    task automatic do_req(input logic w, input logic [5:0] a, input logic [31:0] d,
                          input int waits, input logic err);
        int   budget;
        exp_t e;
        slv_t s;
        logic tmo;
        budget    = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && budget < 200) begin
            @(negedge pclk);
            budget++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_ready_timeout: got req_ready=0 for 200 cycles, expected 1");
            req_valid = 1'b0;
            return;
        end
`ifdef APB_TIMEOUT_EN
        tmo = (waits >= TO);
`else
        tmo = 1'b0;
`endif
        e.err   = err || tmo;
        e.rdata = (w || e.err) ? 32'd0 : ref_mem[a[5:2]];
`ifdef APB_TIMEOUT_EN
        e.cyc   = cyc + 3 + (tmo ? TO - 1 : waits);
`else
        e.cyc   = cyc + 3 + waits;
`endif
        if (w && !e.err) ref_mem[a[5:2]] = d;
        s.w     = w;
        s.paddr = {a[5:2], 2'b00};
        s.wdata = d;
        s.waits = waits;
        s.err   = err;
        exp_q.push_back(e);
        slv_q.push_back(s);
        @(negedge pclk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 6'($urandom);
        req_wdata = $urandom;
        chk("setup_psel", 64'(psel), 64'd1);
        chk("setup_penable", 64'(penable), 64'd0);
        chk("setup_req_ready", 64'(req_ready), 64'd0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            @(negedge pclk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            slv_mem[i] = '0;
        end
        presetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        presetn = 1'b1;
        #1 chk("rel_req_ready_low", 64'(req_ready), 64'd0);
        @(negedge pclk);
        chk("rel_req_ready_high", 64'(req_ready), 64'd1);

        // Directed: write, read-back, wait states, slave error
        do_req(1'b1, 6'h12, 32'hDEADBEEF, 0, 1'b0);
        do_req(1'b0, 6'h12, 32'h0, 0, 1'b0);
        do_req(1'b0, 6'h12, 32'h0, 3, 1'b0);
        do_req(1'b0, 6'h12, 32'h0, 0, 1'b1);
        do_req(1'b1, 6'h07, 32'h12345678, 2, 1'b1);
        do_req(1'b0, 6'h04, 32'h0, 1, 1'b0);
        drain();

        // Random traffic with idle gaps and back-to-back attempts
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            do_req(1'($urandom), 6'($urandom), $urandom, int'($urandom_range(0, 4)),
                   ($urandom_range(0, 7) == 0));
        end
        drain();

`ifdef APB_TIMEOUT_EN
        do_req(1'b0, 6'h20, 32'h0, 1000, 1'b0);
        do_req(1'b1, 6'h24, 32'hCAFEF00D, 1000, 1'b0);
        drain();
        do_req(1'b0, 6'h24, 32'h0, 0, 1'b0);
        drain();
`endif

        // Reset in the middle of ACCESS: bus drops at once, no response
        do_req(1'b0, 6'h08, 32'h0, 6, 1'b0);
        @(negedge pclk);
        chk("mid_access_psel", 64'(psel), 64'd1);
        chk("mid_access_penable", 64'(penable), 64'd1);
        presetn = 1'b0;
        exp_q.delete();
        slv_q.delete();
        #1;
        chk("arst_psel", 64'(psel), 64'd0);
        chk("arst_penable", 64'(penable), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        #1 chk("rel2_req_ready_low", 64'(req_ready), 64'd0);
        @(negedge pclk);
        chk("rel2_req_ready_high", 64'(req_ready), 64'd1);
        repeat (10) @(negedge pclk);
        do_req(1'b0, 6'h12, 32'h0, 0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
